instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 13 +
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit: default widths, halt encoding
// and the two fetch states.
package instr_fetch_pkg;

  localparam int          DEF_ADDR_W    = 8;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          FETCH_CNT_W   = 16;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/instr_fetch.sv
// Single-slot instruction fetch unit with redirect, halt-on-HALT_WORD and resume.
// Optional handshake counter enabled by defining INSTR_FETCH_PERF_CNT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted,
  input  logic              resume
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [FETCH_CNT_W-1:0] fetch_cnt
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [0:0]        state;
  logic              handshake;
  logic              load;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALTED);
  assign handshake = instr_valid & instr_ready;
  assign load      = (state == ST_RUN) & (~instr_valid | instr_ready);

  // Redirect outranks everything; a halt word is delivered like any other and
  // only afterwards does the unit stop loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_target;
      instr_valid <= 1'b0;
      state       <= ST_RUN;
    end else if (load) begin
      pc          <= pc + ADDR_W'(1);
      instr_valid <= 1'b1;
      instr_data  <= imem_rdata;
      instr_pc    <= pc;
      if (imem_rdata == HALT_WORD) begin
        state <= ST_HALTED;
      end
    end else begin
      if (handshake) begin
        instr_valid <= 1'b0;
      end
      if ((state == ST_HALTED) && resume) begin
        state <= ST_RUN;
      end
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  // Saturating count of accepted instructions; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (handshake && (fetch_cnt != {FETCH_CNT_W{1'b1}})) begin
      fetch_cnt <= fetch_cnt + FETCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational memory model
// holding word = address, plus a halt word at 8'h0A.
`timescale 1ns/1ps
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        halted;
  logic        resume;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  logic [31:0] mem [256];
  int checks;
  int failures;

  assign imem_rdata = mem[imem_addr];

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .halted          (halted),
    .resume          (resume)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid got=%0b exp=0", instr_valid);
    end
    checks++;
    if (imem_addr !== 8'h00 || instr_pc !== 8'h00 || instr_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_regs addr=%h pc=%h data=%h exp=0/0/0", imem_addr, instr_pc, instr_data);
    end
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_halted got=%0b exp=0", halted);
    end
  endtask

  // Stream words 0..5 with ready held high; first word valid one edge after release.
  task automatic test_stream();
    instr_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr_data !== 32'(i)) begin
        failures++;
        $display("[TB] FAIL stream_%0d valid=%0b pc=%h data=%h exp=1/%h/%h",
                 i, instr_valid, instr_pc, instr_data, 8'(i), 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h05 || instr_data !== 32'h5) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d valid=%0b pc=%h data=%h exp=1/05/5",
                 i, instr_valid, instr_pc, instr_data);
      end
    end
    instr_ready = 1'b1;
    for (int i = 6; i < 8; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr_data !== 32'(i)) begin
        failures++;
        $display("[TB] FAIL stall_resume_%0d valid=%0b pc=%h exp=1/%h", i, instr_valid, instr_pc, 8'(i));
      end
    end
  endtask

  // Word 8'h07 is pending with ready low when the redirect arrives.
  task automatic test_redirect();
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 8'h40;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 8'h40) begin
      failures++;
      $display("[TB] FAIL redirect_drop valid=%0b addr=%h exp=0/40", instr_valid, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || instr_data !== 32'h40) begin
      failures++;
      $display("[TB] FAIL redirect_target valid=%0b pc=%h data=%h exp=1/40/40",
               instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1;
    redirect_target = 8'h08;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h0A || instr_data !== 32'hFFFF_FFFF || halted !== 1'b1) begin
      failures++;
      $display("[TB] FAIL halt_deliver valid=%0b pc=%h data=%h halted=%0b exp=1/0a/ffffffff/1",
               instr_valid, instr_pc, instr_data, halted);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h0B) begin
        failures++;
        $display("[TB] FAIL halt_idle_%0d valid=%0b halted=%0b addr=%h exp=0/1/0b",
                 i, instr_valid, halted, imem_addr);
      end
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_resume halted=%0b valid=%0b exp=0/0", halted, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h0B) begin
      failures++;
      $display("[TB] FAIL halt_next valid=%0b pc=%h exp=1/0b", instr_valid, instr_pc);
    end
  endtask

  // Redirect while halted wins over a simultaneous resume.
  task automatic test_halt_redirect();
    redirect_valid = 1'b1;
    redirect_target = 8'h09;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hredir_halted halted=%0b valid=%0b exp=1/0", halted, instr_valid);
    end
    redirect_valid = 1'b1;
    redirect_target = 8'h20;
    resume = 1'b1;
    step();
    redirect_valid = 1'b0;
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 8'h20) begin
      failures++;
      $display("[TB] FAIL hredir_leave halted=%0b valid=%0b addr=%h exp=0/0/20",
               halted, instr_valid, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h20 || instr_data !== 32'h20) begin
      failures++;
      $display("[TB] FAIL hredir_next valid=%0b pc=%h exp=1/20", instr_valid, instr_pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE;
    exp_pc[1] = 8'hFF;
    exp_pc[2] = 8'h00;
    exp_pc[3] = 8'h01;
    rst_n = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_target = 8'hFE;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr_data !== 32'(exp_pc[i])) begin
        failures++;
        $display("[TB] FAIL wrap_%0d valid=%0b pc=%h exp=1/%h", i, instr_valid, instr_pc, exp_pc[i]);
      end
    end
    step();
`ifdef INSTR_FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 16'd4) begin
      failures++;
      $display("[TB] FAIL wrap_cnt got=%0d exp=4", fetch_cnt);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 8'h00 || halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset valid=%0b addr=%h halted=%0b exp=0/00/0",
               instr_valid, imem_addr, halted);
    end
`ifdef INSTR_FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_cnt got=%0d exp=0", fetch_cnt);
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    mem[8'h0A] = DEF_HALT_WORD;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    resume = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
